vector3_arith_pipe: RTL and testbench



---
 rtl/vector_arith_pkg.sv | 15 +
 rtl/vector_sat_scale.sv | 34 +++
 rtl/vector3_arith_pipe.sv | 186 ++++++++++++++++++
 tb/tb_vector3_arith_pipe.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vector_arith_pkg.sv
// Shared types and constants for the fixed-point 3-vector arithmetic engine.
package vector_arith_pkg;

    localparam int VEC_IBITS      = 12;
    localparam int VEC_FBITS      = 20;
    localparam int VARITH_LATENCY = 4;

    typedef enum logic [1:0] {
        VOP_CROSS = 2'b00,
        VOP_DOT   = 2'b01,
        VOP_SUB   = 2'b10,
        VOP_ADD   = 2'b11
    } vop_e;

endpackage

// File: rtl/vector_sat_scale.sv
// One result lane: optional floor shift by SHIFT bits, then clamp to a W-bit
// signed range with a flag raised when the clamp engages.
module vector_sat_scale #(
    parameter int IN_W  = 66,
    parameter int SHIFT = 20,
    parameter int W     = 32
) (
    input  logic signed [IN_W-1:0] i_val,
    input  logic                   i_shift,
    output logic [W-1:0]           o_val,
    output logic                   o_sat
);

    localparam logic signed [IN_W-1:0] MAX_V = {{(IN_W-W+1){1'b0}}, {(W-1){1'b1}}};
    localparam logic signed [IN_W-1:0] MIN_V = {{(IN_W-W+1){1'b1}}, {(W-1){1'b0}}};

    logic signed [IN_W-1:0] w_scaled;

    // Arithmetic shift rounds toward negative infinity.
    assign w_scaled = i_shift ? (i_val >>> SHIFT) : i_val;

    always_comb begin
        o_sat = 1'b0;
        o_val = w_scaled[W-1:0];
        if (w_scaled > MAX_V) begin
            o_val = {1'b0, {(W-1){1'b1}}};
            o_sat = 1'b1;
        end else if (w_scaled < MIN_V) begin
            o_val = {1'b1, {(W-1){1'b0}}};
            o_sat = 1'b1;
        end
    end

endmodule

// File: rtl/vector3_arith_pipe.sv
// Four-stage fixed-point 3-vector engine (cross, dot, sub, add) with a global
// stall: operand reg -> six products -> combine -> rescale/saturate output reg.
module vector3_arith_pipe
    import vector_arith_pkg::*;
#(
    parameter int IBITS = VEC_IBITS,
    parameter int FBITS = VEC_FBITS,
    parameter int TAG_W = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [1:0]                   in_op,
    input  logic [3*(IBITS+FBITS)-1:0]   in_a,
    input  logic [3*(IBITS+FBITS)-1:0]   in_b,
    input  logic [TAG_W-1:0]             in_tag,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [3*(IBITS+FBITS)-1:0]   out_vec,
    output logic [TAG_W-1:0]             out_tag,
    output logic                         out_sat
);

    localparam int W  = IBITS + FBITS;
    localparam int PW = 2 * W;
    localparam int LW = 2 * W + 2;

    // Handshake: a transfer happens on a rising edge where valid && ready are
    // both high; in_ready is the global enable, so a held output freezes every
    // stage and new operands wait until the consumer takes the result.
    logic w_en;

    logic                  r1_valid;
    vop_e                  r1_op;
    logic [3*W-1:0]        r1_a, r1_b;
    logic [TAG_W-1:0]      r1_tag;

    logic                  r2_valid;
    vop_e                  r2_op;
    logic [3*W-1:0]        r2_a, r2_b;
    logic [TAG_W-1:0]      r2_tag;
    logic signed [PW-1:0]  r2_p [6];
    logic signed [PW-1:0]  w_p  [6];

    logic                  r3_valid;
    logic                  r3_shift;
    logic [TAG_W-1:0]      r3_tag;
    logic signed [LW-1:0]  r3_lane [3];
    logic signed [LW-1:0]  w_lane  [3];
    logic                  w_shift;

    logic                  r4_valid;
    logic [3*W-1:0]        r4_vec;
    logic [TAG_W-1:0]      r4_tag;
    logic                  r4_sat;
    logic [3*W-1:0]        w_sat_vec;
    logic [2:0]            w_sat_flag;

    function automatic logic [W-1:0] lane(input logic [3*W-1:0] v, input int i);
        return v[(2-i)*W +: W];
    endfunction

    function automatic logic signed [PW-1:0] mul(input logic [W-1:0] x, input logic [W-1:0] y);
        logic signed [PW-1:0] xe;
        logic signed [PW-1:0] ye;
        xe = {{W{x[W-1]}}, x};
        ye = {{W{y[W-1]}}, y};
        return xe * ye;
    endfunction

    function automatic logic signed [LW-1:0] sext_p(input logic [PW-1:0] p);
        return {{2{p[PW-1]}}, p};
    endfunction

    function automatic logic signed [LW-1:0] sext_w(input logic [W-1:0] x);
        return {{(LW-W){x[W-1]}}, x};
    endfunction

    assign w_en     = !r4_valid || out_ready;
    assign in_ready = w_en;

    // Lane index 0 is x, 1 is y, 2 is z.
    always_comb begin
        for (int k = 0; k < 6; k++) w_p[k] = '0;
        if (r1_op == VOP_DOT) begin
            w_p[0] = mul(lane(r1_a, 0), lane(r1_b, 0));
            w_p[1] = mul(lane(r1_a, 1), lane(r1_b, 1));
            w_p[2] = mul(lane(r1_a, 2), lane(r1_b, 2));
        end else begin
            w_p[0] = mul(lane(r1_a, 1), lane(r1_b, 2));
            w_p[1] = mul(lane(r1_a, 2), lane(r1_b, 1));
            w_p[2] = mul(lane(r1_a, 2), lane(r1_b, 0));
            w_p[3] = mul(lane(r1_a, 0), lane(r1_b, 2));
            w_p[4] = mul(lane(r1_a, 0), lane(r1_b, 1));
            w_p[5] = mul(lane(r1_a, 1), lane(r1_b, 0));
        end
    end

    always_comb begin
        for (int k = 0; k < 3; k++) w_lane[k] = '0;
        w_shift = (r2_op == VOP_CROSS) || (r2_op == VOP_DOT);
        case (r2_op)
            VOP_CROSS: begin
                w_lane[0] = sext_p(r2_p[0]) - sext_p(r2_p[1]);
                w_lane[1] = sext_p(r2_p[2]) - sext_p(r2_p[3]);
                w_lane[2] = sext_p(r2_p[4]) - sext_p(r2_p[5]);
            end
            VOP_DOT: begin
                w_lane[0] = sext_p(r2_p[0]) + sext_p(r2_p[1]) + sext_p(r2_p[2]);
            end
            VOP_SUB: begin
                for (int k = 0; k < 3; k++)
                    w_lane[k] = sext_w(lane(r2_a, k)) - sext_w(lane(r2_b, k));
            end
            VOP_ADD: begin
                for (int k = 0; k < 3; k++)
                    w_lane[k] = sext_w(lane(r2_a, k)) + sext_w(lane(r2_b, k));
            end
            default: ;
        endcase
    end

    for (genvar g = 0; g < 3; g++) begin : g_lane
        vector_sat_scale #(
            .IN_W  (LW),
            .SHIFT (FBITS),
            .W     (W)
        ) u_sat (
            .i_val   (r3_lane[g]),
            .i_shift (r3_shift),
            .o_val   (w_sat_vec[(2-g)*W +: W]),
            .o_sat   (w_sat_flag[g])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r1_valid <= 1'b0;
            r1_op    <= VOP_CROSS;
            r1_a     <= '0;
            r1_b     <= '0;
            r1_tag   <= '0;
            r2_valid <= 1'b0;
            r2_op    <= VOP_CROSS;
            r2_a     <= '0;
            r2_b     <= '0;
            r2_tag   <= '0;
            for (int k = 0; k < 6; k++) r2_p[k] <= '0;
            r3_valid <= 1'b0;
            r3_shift <= 1'b0;
            r3_tag   <= '0;
            for (int k = 0; k < 3; k++) r3_lane[k] <= '0;
            r4_valid <= 1'b0;
            r4_vec   <= '0;
            r4_tag   <= '0;
            r4_sat   <= 1'b0;
        end else if (w_en) begin
            r1_valid <= in_valid;
            r1_op    <= vop_e'(in_op);
            r1_a     <= in_a;
            r1_b     <= in_b;
            r1_tag   <= in_tag;
            r2_valid <= r1_valid;
            r2_op    <= r1_op;
            r2_a     <= r1_a;
            r2_b     <= r1_b;
            r2_tag   <= r1_tag;
            for (int k = 0; k < 6; k++) r2_p[k] <= w_p[k];
            r3_valid <= r2_valid;
            r3_shift <= w_shift;
            r3_tag   <= r2_tag;
            for (int k = 0; k < 3; k++) r3_lane[k] <= w_lane[k];
            r4_valid <= r3_valid;
            r4_vec   <= w_sat_vec;
            r4_tag   <= r3_tag;
            r4_sat   <= |w_sat_flag;
        end
    end

    assign out_valid = r4_valid;
    assign out_vec   = r4_vec;
    assign out_tag   = r4_tag;
    assign out_sat   = r4_sat;

endmodule

// File: tb/tb_vector3_arith_pipe.sv
// Bench for vector3_arith_pipe: directed cases, backpressure, mixed random
// streams and mid-flight reset, checked against an arithmetic reference model.
module tb_vector3_arith_pipe;
  import vector_arith_pkg::*;

  localparam int IBITS = 12;
  localparam int FBITS = 20;
  localparam int TAG_W = 8;
  localparam int W     = IBITS + FBITS;
  localparam int VW    = 3 * W;
  localparam int EW    = 1 + TAG_W + VW;
  localparam logic [31:0] ONE = 32'h0010_0000;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [1:0]       in_op = 2'd0;
  logic [VW-1:0]    in_a = '0;
  logic [VW-1:0]    in_b = '0;
  logic [TAG_W-1:0] in_tag = '0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [VW-1:0]    out_vec;
  logic [TAG_W-1:0] out_tag;
  logic             out_sat;

  always #5 clk = ~clk;

  vector3_arith_pipe #(
    .IBITS (IBITS),
    .FBITS (FBITS),
    .TAG_W (TAG_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_vec   (out_vec),
    .out_tag   (out_tag),
    .out_sat   (out_sat)
  );

  logic [EW-1:0]    exp_q[$];
  int               checks = 0;
  int               errors = 0;
  logic             acc_flag = 1'b0;
  logic             prev_stalled = 1'b0;
  logic [VW-1:0]    prev_vec = '0;
  logic [TAG_W-1:0] prev_tag = '0;
  logic             prev_sat = 1'b0;
  logic [VW-1:0]    last_vec = '0;
  logic [TAG_W-1:0] last_tag = '0;
  logic             last_sat = 1'b0;

  task automatic check(input string name, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  function automatic logic [VW-1:0] mk(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
    return {x, y, z};
  endfunction

  function automatic logic signed [127:0] to_int(input logic signed [31:0] x);
    return x;
  endfunction

  // Reference: exact integer math, floor division by 2^FBITS, then clamp.
  function automatic logic [EW-1:0] model(input logic [1:0] op, input logic [VW-1:0] a,
                                          input logic [VW-1:0] b, input logic [TAG_W-1:0] tag);
    logic signed [127:0] av[3];
    logic signed [127:0] bv[3];
    logic signed [127:0] r[3];
    logic signed [127:0] q;
    logic signed [127:0] den;
    logic signed [127:0] maxv;
    logic signed [127:0] minv;
    logic [VW-1:0]       v;
    logic                s;
    den  = 128'sd1048576;
    maxv = 128'sd2147483647;
    minv = -128'sd2147483648;
    for (int k = 0; k < 3; k++) begin
      av[k] = to_int(a[(2-k)*32 +: 32]);
      bv[k] = to_int(b[(2-k)*32 +: 32]);
    end
    case (op)
      2'd0: begin
        r[0] = av[1]*bv[2] - av[2]*bv[1];
        r[1] = av[2]*bv[0] - av[0]*bv[2];
        r[2] = av[0]*bv[1] - av[1]*bv[0];
      end
      2'd1: begin
        r[0] = av[0]*bv[0] + av[1]*bv[1] + av[2]*bv[2];
        r[1] = 0;
        r[2] = 0;
      end
      2'd2: for (int k = 0; k < 3; k++) r[k] = av[k] - bv[k];
      default: for (int k = 0; k < 3; k++) r[k] = av[k] + bv[k];
    endcase
    s = 1'b0;
    v = '0;
    for (int k = 0; k < 3; k++) begin
      q = r[k];
      if (op < 2'd2) begin
        q = r[k] / den;
        if ((r[k] % den) != 0 && r[k] < 0) q = q - 1;
      end
      if (q > maxv) begin
        v[(2-k)*32 +: 32] = 32'h7FFF_FFFF;
        s = 1'b1;
      end else if (q < minv) begin
        v[(2-k)*32 +: 32] = 32'h8000_0000;
        s = 1'b1;
      end else begin
        v[(2-k)*32 +: 32] = q[31:0];
      end
    end
    return {s, tag, v};
  endfunction

  function automatic logic [31:0] rand_lane();
    logic [31:0] b;
    b = $urandom;
    if ($urandom_range(0, 2) != 0) return {{8{b[23]}}, b[23:0]};
    return b;
  endfunction

  // One clock: sample handshakes just after the falling edge, then advance.
  task automatic cycle();
    logic [EW-1:0] e;
    #1;
    check("in_ready", in_ready, !(out_valid && !out_ready));
    if (prev_stalled) begin
      check("stall_valid", out_valid, 1'b1);
      check("stall_vec", out_vec, prev_vec);
      check("stall_tag", out_tag, prev_tag);
      check("stall_sat", out_sat, prev_sat);
    end
    acc_flag = in_valid && in_ready;
    if (acc_flag) exp_q.push_back(model(in_op, in_a, in_b, in_tag));
    if (out_valid && out_ready) begin
      checks++;
      assert (exp_q.size() != 0) else begin
        errors++;
        $error("FAIL spurious_result: observed tag %0h expected no result", out_tag);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("out_vec", out_vec, e[VW-1:0]);
        check("out_tag", out_tag, e[VW+TAG_W-1:VW]);
        check("out_sat", out_sat, e[EW-1]);
        last_vec = out_vec;
        last_tag = out_tag;
        last_sat = out_sat;
      end
    end
    prev_stalled = out_valid && !out_ready;
    prev_vec = out_vec;
    prev_tag = out_tag;
    prev_sat = out_sat;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run_one(input logic [1:0] op, input logic [VW-1:0] a, input logic [VW-1:0] b,
                         input logic [TAG_W-1:0] tag);
    int lat;
    out_ready = 1'b1;
    in_valid = 1'b1;
    in_op = op;
    in_a = a;
    in_b = b;
    in_tag = tag;
    cycle();
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      cycle();
      lat++;
    end
    check("latency", lat, VARITH_LATENCY);
    cycle();
  endtask

  // mode 0: ready low for cycles 6-10; mode 1: ready always; mode 2: random.
  task automatic stream(input int n, input int mode, input int tag_base);
    int  acc;
    bit  pend;
    acc = 0;
    pend = 1'b0;
    for (int c = 0; c < 400 && (acc < n || exp_q.size() != 0); c++) begin
      if (!pend && acc < n && (mode != 2 || $urandom_range(0, 3) != 0)) begin
        in_op  = (mode == 1) ? 2'(acc % 4) : 2'($urandom_range(0, 3));
        in_a   = mk(rand_lane(), rand_lane(), rand_lane());
        in_b   = mk(rand_lane(), rand_lane(), rand_lane());
        in_tag = TAG_W'(tag_base + acc);
        pend   = 1'b1;
      end
      in_valid = pend;
      case (mode)
        0:       out_ready = !(c >= 6 && c <= 10);
        1:       out_ready = 1'b1;
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      if (mode == 1 && c >= VARITH_LATENCY && c < n + VARITH_LATENCY)
        check("b2b_valid", out_valid, 1'b1);
      cycle();
      if (acc_flag) begin
        acc++;
        pend = 1'b0;
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    check("stream_count", acc, n);
    check("stream_drain", exp_q.size(), 0);
  endtask

  initial begin
    // Asynchronous reset, checked before any clock edge.
    #2 rst_n = 1'b0;
    #1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_vec", out_vec, '0);
    check("rst_out_tag", out_tag, '0);
    check("rst_out_sat", out_sat, 1'b0);
    check("rst_in_ready", in_ready, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    cycle();

    run_one(2'd0, mk(ONE, 0, 0), mk(0, ONE, 0), 8'h11);
    check("cross_vec", last_vec, mk(0, 0, ONE));
    check("cross_tag", last_tag, 8'h11);
    check("cross_sat", last_sat, 1'b0);

    run_one(2'd1, mk(32'h0010_0000, 32'h0020_0000, 32'h0030_0000),
            mk(32'h0040_0000, 32'h0050_0000, 32'h0060_0000), 8'h22);
    check("dot_vec", last_vec, mk(32'h0200_0000, 0, 0));
    check("dot_sat", last_sat, 1'b0);

    run_one(2'd1, mk(32'hFFFF_FFFF, 0, 0), mk(32'h0000_0001, 0, 0), 8'h23);
    check("dot_floor", last_vec, mk(32'hFFFF_FFFF, 0, 0));

    run_one(2'd1, mk(32'h7D00_0000, 0, 0), mk(32'h7D00_0000, 0, 0), 8'h24);
    check("dot_satpos_vec", last_vec, mk(32'h7FFF_FFFF, 0, 0));
    check("dot_satpos_sat", last_sat, 1'b1);

    run_one(2'd2, mk(32'h8000_0000, 0, 0), mk(ONE, 0, 0), 8'h25);
    check("sub_satneg_vec", last_vec, mk(32'h8000_0000, 0, 0));
    check("sub_satneg_sat", last_sat, 1'b1);

    stream(10, 0, 1);
    stream(40, 1, 8'h40);
    stream(60, 2, 8'h80);

    // Three ops in flight with the oldest held at the output, then reset.
    out_ready = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_op  = 2'(i);
      in_a   = mk(rand_lane(), rand_lane(), rand_lane());
      in_b   = mk(rand_lane(), rand_lane(), rand_lane());
      in_tag = TAG_W'(8'hC0 + i);
      cycle();
    end
    in_valid = 1'b0;
    cycle();
    check("pre_rst_valid", out_valid, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_valid", out_valid, 1'b0);
    check("mid_rst_vec", out_vec, '0);
    check("mid_rst_tag", out_tag, '0);
    check("mid_rst_in_ready", in_ready, 1'b1);
    exp_q.delete();
    prev_stalled = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check("post_rst_valid", out_valid, 1'b0);
      cycle();
    end
    check("final_queue", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
